conv_frame_ctrl: RTL and testbench
==================================

CONV_FRAME_CTRL -- requirements
Module: conv_frame_ctrl

Interface
REQ-001 Parameter NUM, default 11'b111_1111_1111 (2047), data bits per frame; legal range 1 <= NUM < 2^LEN.
REQ-002 Parameter LEN, default 11, width of counter_sig.
REQ-003 Parameter TAIL, default 6, flush (tail) bits per frame; legal range 1 <= TAIL <= NUM.
REQ-004 clk_sig  in  1  single clock; all state changes on rising edge.
REQ-005 reset_sig  in  1  asynchronous, active-low reset.
REQ-006 start_sig  in  1  request to begin one frame; sampled only in IDLE.
REQ-007 abort_sig  in  1  synchronous abort of the frame in progress.
REQ-008 in_valid_sig  in  1  upstream data bit valid.
REQ-009 in_bit_sig  in  1  upstream data bit.
REQ-010 in_ready_sig  out  1  controller accepts a data bit this cycle.
REQ-011 enc_clr_sig  out  1  registered one-cycle pulse clearing the encoder shift register.
REQ-012 enc_en_sig  out  1  encoder shift enable.
REQ-013 enc_bit_sig  out  1  bit presented to the encoder.
REQ-014 counter_sig  out  LEN  bit index within the current phase.
REQ-015 state_sig  out  2  current state: IDLE=0, DATA=1, TAIL=2, DONE=3.
REQ-016 busy_sig  out  1  high whenever state != IDLE.
REQ-017 done_sig  out  1  one-cycle pulse per completed frame.
REQ-018 frame_cnt_sig  out  8  count of completed frames.

Function
REQ-019 IDLE with start_sig=1 and abort_sig=0 SHALL go to DATA next cycle, with counter_sig=0 and enc_clr_sig=1 for exactly that first DATA cycle.
REQ-020 start_sig outside IDLE SHALL be ignored; no queuing.
REQ-021 in_ready_sig SHALL be combinational: (state==DATA) && !abort_sig.
REQ-022 Transfer SHALL occur when in_valid_sig && in_ready_sig; only then does DATA advance; in_valid_sig=0 stalls the phase indefinitely with counter_sig held.
REQ-023 enc_en_sig SHALL be combinational: transfer in DATA, or state==TAIL && !abort_sig; 0 otherwise.
REQ-024 enc_bit_sig SHALL be in_bit_sig in DATA and 0 in every other state.
REQ-025 counter_sig SHALL increment by 1 on each cycle with enc_en_sig=1, except at the phase-end cycles in REQ-026/REQ-027.
REQ-026 DATA transfer with counter_sig==NUM-1 SHALL go to TAIL with counter_sig=0.
REQ-027 TAIL with counter_sig==TAIL-1 SHALL go to DONE with counter_sig=0; TAIL never stalls.
REQ-028 DONE SHALL last one cycle with done_sig=1, then go to IDLE; frame_cnt_sig SHALL increment in the same cycle as the DONE transition, wrapping 255->0.
REQ-029 abort_sig=1 in DATA or TAIL SHALL force enc_en_sig=0 and in_ready_sig=0 that cycle, then go to IDLE with counter_sig=0; it SHALL produce no done_sig and no frame_cnt_sig change.
REQ-030 abort_sig in DONE SHALL be ignored; the frame counts as complete.
REQ-031 abort_sig and start_sig together in IDLE: abort_sig wins and the block stays in IDLE.
REQ-032 Unstalled frame latency: start accepted at cycle 0; DATA spans cycles 1..NUM; TAIL spans NUM+1..NUM+TAIL; done_sig is high at NUM+TAIL+1; IDLE at NUM+TAIL+2; next start accepted at NUM+TAIL+2.
REQ-033 The next state of an illegal encoding (none reachable) SHALL be IDLE.

Reset
REQ-034 reset_sig=0 SHALL immediately (asynchronously) force state IDLE, counter_sig=0, enc_clr_sig=0, done_sig=0, frame_cnt_sig=0, busy_sig=0; combinational outputs SHALL follow IDLE values.
REQ-035 Reset asserted mid-frame SHALL discard the frame with no done_sig; operation resumes on the first rising clk_sig after reset_sig returns high.

Verification (NUM=8, TAIL=2, LEN=4 unless stated)
REQ-036 Start pulse, in_valid_sig held 1, bits 10110011 -> enc_clr_sig at cycle 1; enc_en_sig at cycles 1-10; enc_bit_sig=1,0,1,1,0,0,1,1,0,0; done_sig at cycle 11; frame_cnt_sig=1.
REQ-037 Drop in_valid_sig for 3 cycles after the 4th bit -> counter_sig holds at 4, enc_en_sig=0 during the gap, done_sig delayed exactly 3 cycles.
REQ-038 abort_sig when counter_sig=5 in DATA, and again in a second frame at TAIL counter_sig=1 -> IDLE the next cycle each time; no done_sig; frame_cnt_sig unchanged.
REQ-039 reset_sig low mid-TAIL between clock edges -> outputs reach reset values before the next edge; start after release runs a full normal frame.
REQ-040 256 back-to-back frames with start held 1 -> frame_cnt_sig wraps to 0; each frame lasts 12 cycles including IDLE; start during busy is ignored.
REQ-041 Defaults NUM=2047, TAIL=6, LEN=11 -> counter_sig reaches 2046 in DATA without overflow; done_sig at cycle 2054.

Source files
------------

// File: rtl/conv_frame_ctrl.sv
// Frame controller for a convolutional encoder: accepts NUM data bits from
// upstream, appends TAIL zero flush bits, then reports frame completion.
module conv_frame_ctrl #(
  parameter int NUM  = 2047,
  parameter int LEN  = 11,
  parameter int TAIL = 6
) (
  input  logic           clk_sig,
  input  logic           reset_sig,
  input  logic           start_sig,
  input  logic           abort_sig,
  input  logic           in_valid_sig,
  input  logic           in_bit_sig,
  output logic           in_ready_sig,
  output logic           enc_clr_sig,
  output logic           enc_en_sig,
  output logic           enc_bit_sig,
  output logic [LEN-1:0] counter_sig,
  output logic [1:0]     state_sig,
  output logic           busy_sig,
  output logic           done_sig,
  output logic [7:0]     frame_cnt_sig
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_TAIL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [LEN-1:0] DATA_LAST = LEN'(NUM - 1);
  localparam logic [LEN-1:0] TAIL_LAST = LEN'(TAIL - 1);

  state_t         state;
  state_t         state_nxt;
  logic [LEN-1:0] counter_nxt;
  logic           clr_nxt;
  logic           frame_inc;
  logic           transfer;

  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      state         <= S_IDLE;
      counter_sig   <= '0;
      enc_clr_sig   <= 1'b0;
      frame_cnt_sig <= 8'd0;
    end else begin
      state       <= state_nxt;
      counter_sig <= counter_nxt;
      enc_clr_sig <= clr_nxt;
      if (frame_inc)
        frame_cnt_sig <= frame_cnt_sig + 8'd1;
    end
  end

  always_comb begin
    state_nxt    = state;
    counter_nxt  = counter_sig;
    clr_nxt      = 1'b0;
    frame_inc    = 1'b0;
    in_ready_sig = (state == S_DATA) && !abort_sig;
    transfer     = in_ready_sig && in_valid_sig;
    enc_en_sig   = transfer || ((state == S_TAIL) && !abort_sig);
    enc_bit_sig  = (state == S_DATA) ? in_bit_sig : 1'b0;

    // Abort always lands in IDLE with a cleared counter; DONE ignores it.
    case (state)
      S_IDLE: begin
        if (start_sig && !abort_sig) begin
          state_nxt   = S_DATA;
          counter_nxt = '0;
          clr_nxt     = 1'b1;
        end
      end
      S_DATA: begin
        if (abort_sig) begin
          state_nxt   = S_IDLE;
          counter_nxt = '0;
        end else if (transfer) begin
          if (counter_sig == DATA_LAST) begin
            state_nxt   = S_TAIL;
            counter_nxt = '0;
          end else begin
            counter_nxt = counter_sig + 1'b1;
          end
        end
      end
      S_TAIL: begin
        if (abort_sig) begin
          state_nxt   = S_IDLE;
          counter_nxt = '0;
        end else if (counter_sig == TAIL_LAST) begin
          state_nxt   = S_DONE;
          counter_nxt = '0;
          frame_inc   = 1'b1;
        end else begin
          counter_nxt = counter_sig + 1'b1;
        end
      end
      S_DONE: begin
        state_nxt   = S_IDLE;
        counter_nxt = '0;
      end
      default: begin
        state_nxt   = S_IDLE;
        counter_nxt = '0;
      end
    endcase
  end

  assign state_sig = state;
  assign busy_sig  = (state != S_IDLE);
  assign done_sig  = (state == S_DONE);

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Randomized scoreboard bench for conv_frame_ctrl (NUM=8, TAIL=2, LEN=4) plus
// a single long frame on a default-parameter instance.
module tb_conv_frame_ctrl;

  localparam int NUM  = 8;
  localparam int TAIL = 2;
  localparam int LEN  = 4;

  logic           clk_sig = 1'b0;
  logic           reset_sig = 1'b0;
  logic           start_sig = 1'b0;
  logic           abort_sig = 1'b0;
  logic           in_valid_sig = 1'b0;
  logic           in_bit_sig = 1'b0;
  logic           in_ready_sig, enc_clr_sig, enc_en_sig, enc_bit_sig;
  logic [LEN-1:0] counter_sig;
  logic [1:0]     state_sig;
  logic           busy_sig, done_sig;
  logic [7:0]     frame_cnt_sig;

  logic        d_start = 1'b0;
  logic        d_valid = 1'b0;
  logic        d_ready, d_clr, d_en, d_bit, d_busy, d_done;
  logic [10:0] d_cnt;
  logic [1:0]  d_state;
  logic [7:0]  d_frames;

  conv_frame_ctrl #(.NUM(NUM), .LEN(LEN), .TAIL(TAIL)) dut (
    .clk_sig(clk_sig), .reset_sig(reset_sig), .start_sig(start_sig),
    .abort_sig(abort_sig), .in_valid_sig(in_valid_sig), .in_bit_sig(in_bit_sig),
    .in_ready_sig(in_ready_sig), .enc_clr_sig(enc_clr_sig), .enc_en_sig(enc_en_sig),
    .enc_bit_sig(enc_bit_sig), .counter_sig(counter_sig), .state_sig(state_sig),
    .busy_sig(busy_sig), .done_sig(done_sig), .frame_cnt_sig(frame_cnt_sig)
  );

  conv_frame_ctrl dut_dflt (
    .clk_sig(clk_sig), .reset_sig(reset_sig), .start_sig(d_start),
    .abort_sig(1'b0), .in_valid_sig(d_valid), .in_bit_sig(1'b0),
    .in_ready_sig(d_ready), .enc_clr_sig(d_clr), .enc_en_sig(d_en),
    .enc_bit_sig(d_bit), .counter_sig(d_cnt), .state_sig(d_state),
    .busy_sig(d_busy), .done_sig(d_done), .frame_cnt_sig(d_frames)
  );

  always #5 clk_sig = ~clk_sig;

  typedef struct {
    logic b;
    int   idx;
  } enc_t;

  enc_t enc_q[$];
  int   done_q[$];
  int   checks = 0;
  int   fails = 0;
  int   completed = 0;
  int   cyc = 0;
  int   last_done = 0;

  always @(posedge clk_sig) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sig);
    #1;
  endtask

  // The monitor consumes one expected encoder bit per enc_en cycle and one
  // expected frame count per done pulse, independently of the driver.
  initial begin
    enc_t e;
    int   f;
    forever begin
      @(negedge clk_sig);
      if (enc_en_sig === 1'b1) begin
        if (enc_q.size() == 0) check("enc_en_unexpected", 1, 0);
        else begin
          e = enc_q.pop_front();
          check("enc_bit", enc_bit_sig, e.b);
          check("enc_counter", counter_sig, e.idx);
        end
      end
      if (done_sig === 1'b1) begin
        if (done_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          f = done_q.pop_front();
          check("frame_cnt", frame_cnt_sig, f);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, state_sig, 0);
    check({tag, "_counter"}, counter_sig, 0);
    check({tag, "_clr"}, enc_clr_sig, 0);
    check({tag, "_done"}, done_sig, 0);
    check({tag, "_busy"}, busy_sig, 0);
    check({tag, "_frames"}, frame_cnt_sig, 0);
    check({tag, "_ready"}, in_ready_sig, 0);
    check({tag, "_en"}, enc_en_sig, 0);
  endtask

  // plan: 0 normal, 1 abort in DATA at bit 'at', 2 abort in TAIL at 'at',
  // 3 reset between edges in TAIL at 'at'. stall_mode: 0 none, 1 random,
  // 2 three-cycle gap after the 4th bit. Bits are sent MSB first.
  task automatic run_frame(input int plan, input int at, input bit hold,
                           input int stall_mode, input logic [NUM-1:0] bits);
    int c0;
    int stall_total;
    int s;
    stall_total = 0;
    start_sig = 1'b1;
    abort_sig = 1'b0;
    in_valid_sig = 1'($urandom);
    tick();
    c0 = cyc;
    check("first_state", state_sig, 1);
    check("first_clr", enc_clr_sig, 1);
    check("first_counter", counter_sig, 0);
    if (!hold) start_sig = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      if (i == 1) check("clr_pulse", enc_clr_sig, 0);
      s = 0;
      if (stall_mode == 1 && $urandom_range(0, 3) == 0) s = $urandom_range(1, 3);
      if (stall_mode == 2 && i == 4) s = 3;
      repeat (s) begin
        in_valid_sig = 1'b0;
        in_bit_sig = 1'($urandom);
        if (!hold) start_sig = 1'($urandom);
        #1;
        check("stall_en", enc_en_sig, 0);
        tick();
        check("stall_counter", counter_sig, i);
        stall_total++;
      end
      if (plan == 1 && at == i) begin
        abort_sig = 1'b1;
        in_valid_sig = 1'b1;
        in_bit_sig = 1'($urandom);
        #1;
        check("abort_data_ready", in_ready_sig, 0);
        check("abort_data_en", enc_en_sig, 0);
        tick();
        abort_sig = 1'b0;
        check("abort_data_state", state_sig, 0);
        check("abort_data_counter", counter_sig, 0);
        check("abort_data_frames", frame_cnt_sig, completed % 256);
        return;
      end
      in_valid_sig = 1'b1;
      in_bit_sig = bits[NUM-1-i];
      if (!hold) start_sig = 1'($urandom);
      enc_q.push_back('{bits[NUM-1-i], i});
      tick();
    end
    in_valid_sig = 1'($urandom);
    check("tail_state", state_sig, 2);
    check("tail_counter", counter_sig, 0);
    for (int t = 0; t < TAIL; t++) begin
      in_bit_sig = 1'($urandom);
      if (plan == 2 && at == t) begin
        abort_sig = 1'b1;
        #1;
        check("abort_tail_en", enc_en_sig, 0);
        tick();
        abort_sig = 1'b0;
        check("abort_tail_state", state_sig, 0);
        check("abort_tail_counter", counter_sig, 0);
        check("abort_tail_frames", frame_cnt_sig, completed % 256);
        return;
      end
      if (plan == 3 && at == t) begin
        #2;
        reset_sig = 1'b0;
        #1;
        completed = 0;
        check_reset_outputs("midreset");
        @(posedge clk_sig);
        #1;
        reset_sig = 1'b1;
        start_sig = 1'b0;
        tick();
        check("post_reset_state", state_sig, 0);
        return;
      end
      enc_q.push_back('{1'b0, t});
      tick();
    end
    check("done_state", state_sig, 3);
    check("done_pulse", done_sig, 1);
    check("latency", cyc - c0, NUM + TAIL + stall_total);
    completed++;
    done_q.push_back(completed % 256);
    last_done = cyc;
    abort_sig = 1'($urandom);
    if (!hold) start_sig = 1'($urandom);
    tick();
    abort_sig = 1'b0;
    if (!hold) start_sig = 1'b0;
    check("after_done_state", state_sig, 0);
    check("after_done_pulse", done_sig, 0);
  endtask

  initial begin
    int prev;
    int c;
    int maxc;
    int r;
    #12;
    check_reset_outputs("reset");
    @(posedge clk_sig);
    #1;
    reset_sig = 1'b1;
    tick();

    start_sig = 1'b1;
    abort_sig = 1'b1;
    tick();
    check("start_abort_idle", state_sig, 0);
    start_sig = 1'b0;
    abort_sig = 1'b0;
    tick();

    run_frame(0, 0, 1'b0, 0, 8'b10110011);
    run_frame(0, 0, 1'b0, 2, NUM'($urandom));
    run_frame(1, 5, 1'b0, 0, NUM'($urandom));
    run_frame(2, 1, 1'b0, 0, NUM'($urandom));
    run_frame(3, 1, 1'b0, 0, NUM'($urandom));
    run_frame(0, 0, 1'b0, 0, NUM'($urandom));

    // Back-to-back frames with start held high repeat every NUM+TAIL+2 cycles.
    run_frame(0, 0, 1'b1, 0, NUM'($urandom));
    for (int k = 0; k < 3; k++) begin
      prev = last_done;
      run_frame(0, 0, 1'b1, 0, NUM'($urandom));
      check("b2b_period", last_done - prev, NUM + TAIL + 2);
    end
    start_sig = 1'b0;
    tick();

    for (int k = 0; k < 360; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) run_frame(1, $urandom_range(0, NUM - 1), 1'($urandom), 1, NUM'($urandom));
      else if (r == 1) run_frame(2, $urandom_range(0, TAIL - 1), 1'($urandom), 1, NUM'($urandom));
      else run_frame(0, 0, ($urandom_range(0, 4) == 0), $urandom_range(0, 1), NUM'($urandom));
    end
    start_sig = 1'b0;
    tick();
    check("wrapped_frames", (completed >= 256), 1);
    check("final_frames", frame_cnt_sig, completed % 256);

    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    d_valid = 1'b1;
    c = 1;
    maxc = 0;
    while (d_done !== 1'b1 && c < 3000) begin
      if (d_state == 2'd1 && int'(d_cnt) > maxc) maxc = int'(d_cnt);
      tick();
      c++;
    end
    check("dflt_done_cycle", c, 2054);
    check("dflt_max_counter", maxc, 2046);
    tick();
    check("dflt_idle", d_state, 0);

    tick();
    check("enc_q_drained", enc_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
